// File: rtl/piano_pkg.sv
// Shared definitions for the piano note path: message fields, arbiter FSM states
// and owner encodings.
package piano_pkg;

  localparam int unsigned MSG_W      = 8;
  localparam int unsigned MSG_ON_BIT = 7;
  localparam int unsigned MSG_ID_W   = 7;

  typedef struct packed {
    logic                on;
    logic [MSG_ID_W-1:0] id;
  } note_msg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam logic OWNER_KB = 1'b0;
  localparam logic OWNER_AP = 1'b1;

endpackage

// File: rtl/msg_slot.sv
// One-deep pending message register: a write overwrites the held message and
// wins over a clear in the same cycle.
module msg_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wr_msg,
  input  logic         clr,
  output logic         full,
  output logic [W-1:0] msg
);

  logic         full_q, full_d;
  logic [W-1:0] msg_q, msg_d;

  always_comb begin
    full_d = full_q;
    msg_d  = msg_q;
    if (wr) begin
      full_d = 1'b1;
      msg_d  = wr_msg;
    end else if (clr) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      msg_q  <= '0;
    end else begin
      full_q <= full_d;
      msg_q  <= msg_d;
    end
  end

  assign full = full_q;
  assign msg  = msg_q;

endmodule

// File: rtl/msg_arbiter.sv
// Arbitrates keyboard and autoplay note messages onto the single note player.
// Optional MSG_ARB_NOTEID_EN keeps the last granted note-on id on noteid.
module msg_arbiter
  import piano_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 120_000_000,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned HOLDOFF_MS    = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kb_valid,
  input  logic [MSG_W-1:0]    kb_msg,
  input  logic                ap_valid,
  input  logic [MSG_W-1:0]    ap_msg,
  output logic                out_strobe,
  output logic [MSG_W-1:0]    out_msg,
  output logic                owner,
  output logic                kb_active,
  output logic                ap_drop,
  output logic [MSG_ID_W-1:0] noteid
);

  localparam int unsigned HOLD_CYC = CLK_FREQ / 1000 * HOLDOFF_MS;
  localparam int unsigned HOLD_W   = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam int unsigned PH_MAX   = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int unsigned PH_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  arb_state_e        state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [HOLD_W-1:0] holdoff_q, holdoff_d;
  note_msg_t         out_msg_q, out_msg_d;
  logic              owner_q, owner_d;
  logic              kb_active_q, kb_active_d;
  logic              out_strobe_q, out_strobe_d;
  logic              ap_drop_q, ap_drop_d;

  logic              kb_full, ap_full, kb_clr, ap_clr, mute;
  logic [MSG_W-1:0]  kb_raw, ap_raw;
  note_msg_t         kb_data, ap_data;

  assign mute    = kb_active_q || (holdoff_q != '0);
  assign kb_data = note_msg_t'(kb_raw);
  assign ap_data = note_msg_t'(ap_raw);

  msg_slot #(.W(MSG_W)) u_kb_slot (
    .clk    (clk),
    .rst    (rst),
    .wr     (kb_valid),
    .wr_msg (kb_msg),
    .clr    (kb_clr),
    .full   (kb_full),
    .msg    (kb_raw)
  );

  // Autoplay is never written while muted, so the mute clear cannot race a write.
  msg_slot #(.W(MSG_W)) u_ap_slot (
    .clk    (clk),
    .rst    (rst),
    .wr     (ap_valid && !mute),
    .wr_msg (ap_msg),
    .clr    (ap_clr),
    .full   (ap_full),
    .msg    (ap_raw)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    out_msg_d   = out_msg_q;
    owner_d     = owner_q;
    kb_active_d = kb_active_q;
    kb_clr      = 1'b0;
    ap_clr      = mute;
    holdoff_d   = (holdoff_q != '0) ? holdoff_q - HOLD_W'(1) : holdoff_q;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (kb_full) begin
          out_msg_d   = kb_data;
          owner_d     = OWNER_KB;
          kb_clr      = 1'b1;
          kb_active_d = kb_data.on;
          holdoff_d   = kb_data.on ? '0 : HOLD_W'(HOLD_CYC);
          state_d     = EMIT;
        end else if (ap_full && !mute) begin
          out_msg_d = ap_data;
          owner_d   = OWNER_AP;
          ap_clr    = 1'b1;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (phase_q == PH_W'(STROBE_CYCLES - 1)) begin
          phase_d = '0;
          state_d = GAP;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      GAP: begin
        if (phase_q == PH_W'(GAP_CYCLES - 1)) begin
          phase_d = '0;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        phase_d = '0;
        state_d = IDLE;
      end
    endcase

    out_strobe_d = (state_d == EMIT);
    ap_drop_d    = ap_valid && mute;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      holdoff_q    <= '0;
      out_msg_q    <= '0;
      owner_q      <= 1'b0;
      kb_active_q  <= 1'b0;
      out_strobe_q <= 1'b0;
      ap_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      holdoff_q    <= holdoff_d;
      out_msg_q    <= out_msg_d;
      owner_q      <= owner_d;
      kb_active_q  <= kb_active_d;
      out_strobe_q <= out_strobe_d;
      ap_drop_q    <= ap_drop_d;
    end
  end

`ifdef MSG_ARB_NOTEID_EN
  logic [MSG_ID_W-1:0] noteid_q, noteid_d;

  always_comb begin
    noteid_d = noteid_q;
    if ((state_q == IDLE) && (state_d == EMIT) && out_msg_d.on) begin
      noteid_d = out_msg_d.id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) noteid_q <= '0;
    else     noteid_q <= noteid_d;
  end

  assign noteid = noteid_q;
`else
  assign noteid = '0;
`endif

  assign out_strobe = out_strobe_q;
  assign out_msg    = out_msg_q;
  assign owner      = owner_q;
  assign kb_active  = kb_active_q;
  assign ap_drop    = ap_drop_q;

endmodule

// File: tb/tb_msg_arbiter.sv
// Self-checking bench for msg_arbiter: directed scenarios against fixed values
// plus random traffic against a transaction-level reference model.
module tb_msg_arbiter;

  localparam int unsigned S    = 2;
  localparam int unsigned G    = 2;
  localparam int unsigned HOLD = 8;
`ifdef MSG_ARB_NOTEID_EN
  localparam bit NID_EN = 1'b1;
`else
  localparam bit NID_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kb_valid = 1'b0, ap_valid = 1'b0;
  logic [7:0] kb_msg = 8'h00, ap_msg = 8'h00;
  logic       out_strobe, owner, kb_active, ap_drop;
  logic [7:0] out_msg;
  logic [6:0] noteid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  msg_arbiter #(
    .CLK_FREQ      (1000),
    .STROBE_CYCLES (S),
    .GAP_CYCLES    (G),
    .HOLDOFF_MS    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .kb_valid   (kb_valid),
    .kb_msg     (kb_msg),
    .ap_valid   (ap_valid),
    .ap_msg     (ap_msg),
    .out_strobe (out_strobe),
    .out_msg    (out_msg),
    .owner      (owner),
    .kb_active  (kb_active),
    .ap_drop    (ap_drop),
    .noteid     (noteid)
  );

  // Reference model: pending slots, remaining transaction time and an absolute
  // holdoff deadline measured in cycles.
  logic       m_kb_full, m_ap_full, m_owner, m_kb_active, m_ap_drop, m_strobe;
  logic [7:0] m_kb_msg, m_ap_msg, m_out_msg;
  logic [6:0] m_noteid;
  int         m_busy, m_cyc, m_hold_end;

  task automatic model_reset();
    m_kb_full = 0; m_ap_full = 0; m_owner = 0; m_kb_active = 0; m_ap_drop = 0;
    m_strobe = 0; m_kb_msg = 0; m_ap_msg = 0; m_out_msg = 0; m_noteid = 0;
    m_busy = 0; m_hold_end = 0;
  endtask

  task automatic model_step(input logic kbv, input logic [7:0] kbm,
                            input logic apv, input logic [7:0] apm);
    logic mute, gk, ga;
    if (rst) begin
      model_reset();
      m_cyc++;
      return;
    end
    mute = m_kb_active || (m_cyc < m_hold_end);
    gk   = (m_busy == 0) && m_kb_full;
    ga   = (m_busy == 0) && !m_kb_full && m_ap_full && !mute;
    m_ap_drop = apv && mute;
    if (gk) begin
      m_out_msg   = m_kb_msg;
      m_owner     = 1'b0;
      m_kb_active = m_kb_msg[7];
      m_hold_end  = m_kb_msg[7] ? 0 : m_cyc + 1 + HOLD;
    end
    if (ga) begin
      m_out_msg = m_ap_msg;
      m_owner   = 1'b1;
    end
    if ((gk || ga) && m_out_msg[7] && NID_EN) m_noteid = m_out_msg[6:0];
    m_busy   = (gk || ga) ? S + G : ((m_busy > 0) ? m_busy - 1 : 0);
    m_strobe = m_busy > G;
    if (kbv) begin m_kb_full = 1; m_kb_msg = kbm; end
    else if (gk) m_kb_full = 0;
    if (apv && !mute) begin m_ap_full = 1; m_ap_msg = apm; end
    else if (ga || mute) m_ap_full = 0;
    m_cyc++;
  endtask

  task automatic tick(input logic kbv, input logic [7:0] kbm,
                      input logic apv, input logic [7:0] apm);
    kb_valid = kbv; kb_msg = kbm; ap_valid = apv; ap_msg = apm;
    @(posedge clk);
    model_step(kbv, kbm, apv, apm);
    #1;
    kb_valid = 1'b0; ap_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    n_checks++;
    if ({out_strobe, out_msg, owner, kb_active, ap_drop, noteid} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {out_strobe, out_msg, owner, kb_active, ap_drop, noteid});
    end
    rst = 1'b0;
    idle(1);
    n_checks++;
    if (out_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_release_strobe: got %b expected 0", out_strobe); end
  endtask

  task automatic test_ap_basic();
    tick(1'b0, 8'h00, 1'b1, 8'h85);
    n_checks++;
    if (out_strobe !== 1'b0) begin n_fail++; $display("FAIL ap_basic_early: strobe %b expected 0", out_strobe); end
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 8'h00, 1'b0, 8'h00);
      n_checks++;
      if ({out_strobe, out_msg, owner} !== {1'b1, 8'h85, 1'b1}) begin
        n_fail++;
        $display("FAIL ap_basic_emit%0d: strobe/msg/owner %b/%h/%b expected 1/85/1", k, out_strobe, out_msg, owner);
      end
    end
    n_checks++;
    if (noteid !== (NID_EN ? 7'd5 : 7'd0)) begin
      n_fail++; $display("FAIL ap_basic_noteid: got %0d expected %0d", noteid, NID_EN ? 5 : 0);
    end
    tick(1'b0, 8'h00, 1'b0, 8'h00);
    n_checks++;
    if (out_strobe !== 1'b0) begin n_fail++; $display("FAIL ap_basic_width: strobe %b expected 0", out_strobe); end
    idle(2);
  endtask

  task automatic test_priority();
    tick(1'b1, 8'h83, 1'b1, 8'h87);
    tick(1'b0, 8'h00, 1'b0, 8'h00);
    n_checks++;
    if ({out_strobe, out_msg, owner, kb_active} !== {1'b1, 8'h83, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL priority_grant: strobe/msg/owner/active %b/%h/%b/%b expected 1/83/0/1",
               out_strobe, out_msg, owner, kb_active);
    end
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 8'h00, 1'b0, 8'h00);
      n_checks++;
      if ({ap_drop, out_msg} !== {1'b0, 8'h83}) begin
        n_fail++; $display("FAIL priority_no_ap%0d: drop/msg %b/%h expected 0/83", k, ap_drop, out_msg);
      end
    end
  endtask

  task automatic test_mute_drop();
    tick(1'b0, 8'h00, 1'b1, 8'h90);
    n_checks++;
    if (ap_drop !== 1'b1) begin n_fail++; $display("FAIL mute_drop_pulse: got %b expected 1", ap_drop); end
    tick(1'b0, 8'h00, 1'b0, 8'h00);
    n_checks++;
    if (ap_drop !== 1'b0) begin n_fail++; $display("FAIL mute_drop_width: got %b expected 0", ap_drop); end
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 8'h00, 1'b0, 8'h00);
      n_checks++;
      if (out_strobe !== 1'b0) begin n_fail++; $display("FAIL mute_no_strobe%0d: got %b expected 0", k, out_strobe); end
    end
  endtask

  task automatic test_holdoff();
    tick(1'b1, 8'h00, 1'b0, 8'h00);
    tick(1'b0, 8'h00, 1'b0, 8'h00);
    n_checks++;
    if ({out_strobe, out_msg, kb_active} !== {1'b1, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL holdoff_noteoff: strobe/msg/active %b/%h/%b expected 1/00/0", out_strobe, out_msg, kb_active);
    end
    idle(3);
    tick(1'b0, 8'h00, 1'b1, 8'h91);
    n_checks++;
    if (ap_drop !== 1'b1) begin n_fail++; $display("FAIL holdoff_drop: got %b expected 1", ap_drop); end
    idle(4);
    tick(1'b0, 8'h00, 1'b1, 8'h92);
    n_checks++;
    if (ap_drop !== 1'b0) begin n_fail++; $display("FAIL holdoff_expired_drop: got %b expected 0", ap_drop); end
    idle(2);
    n_checks++;
    if ({out_strobe, out_msg, owner} !== {1'b1, 8'h92, 1'b1}) begin
      n_fail++; $display("FAIL holdoff_emit: strobe/msg/owner %b/%h/%b expected 1/92/1", out_strobe, out_msg, owner);
    end
    idle(4);
  endtask

  task automatic test_overwrite();
    tick(1'b1, 8'h81, 1'b0, 8'h00);
    tick(1'b1, 8'h82, 1'b0, 8'h00);
    tick(1'b1, 8'h83, 1'b0, 8'h00);
    n_checks++;
    if ({out_strobe, out_msg} !== {1'b1, 8'h81}) begin
      n_fail++; $display("FAIL overwrite_first: strobe/msg %b/%h expected 1/81", out_strobe, out_msg);
    end
    idle(3);
    n_checks++;
    if ({out_strobe, out_msg} !== {1'b0, 8'h81}) begin
      n_fail++; $display("FAIL overwrite_gap: strobe/msg %b/%h expected 0/81", out_strobe, out_msg);
    end
    idle(1);
    n_checks++;
    if ({out_strobe, out_msg, noteid} !== {1'b1, 8'h83, (NID_EN ? 7'd3 : 7'd0)}) begin
      n_fail++; $display("FAIL overwrite_latest: strobe/msg/id %b/%h/%0d expected 1/83/%0d",
                         out_strobe, out_msg, noteid, NID_EN ? 3 : 0);
    end
    idle(4);
  endtask

  task automatic test_reset_mid_emit();
    tick(1'b1, 8'h84, 1'b0, 8'h00);
    tick(1'b0, 8'h00, 1'b0, 8'h00);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({out_strobe, out_msg, noteid, kb_active} !== 17'd0) begin
      n_fail++; $display("FAIL reset_async: strobe/msg/id/active %b/%h/%0d/%b expected all 0",
                         out_strobe, out_msg, noteid, kb_active);
    end
    idle(1);
    rst = 1'b0;
    tick(1'b1, 8'h05, 1'b0, 8'h00);
    n_checks++;
    if (out_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_idle_latency: strobe %b expected 0", out_strobe); end
    tick(1'b0, 8'h00, 1'b0, 8'h00);
    n_checks++;
    if ({out_strobe, out_msg} !== {1'b1, 8'h05}) begin
      n_fail++; $display("FAIL reset_idle_grant: strobe/msg %b/%h expected 1/05", out_strobe, out_msg);
    end
    idle(4);
  endtask

  task automatic test_random();
    logic       kbv, apv;
    logic [7:0] kbm, apm;
    for (int c = 0; c < 800; c++) begin
      kbv = ($urandom_range(0, 9) == 0);
      apv = ($urandom_range(0, 3) == 0);
      kbm = 8'($urandom);
      apm = 8'($urandom);
      tick(kbv, kbm, apv, apm);
      n_checks++;
      if ({out_strobe, out_msg, owner, kb_active, ap_drop, noteid} !==
          {m_strobe, m_out_msg, m_owner, m_kb_active, m_ap_drop, m_noteid}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: strobe/msg/own/act/drop/id %b/%h/%b/%b/%b/%h expected %b/%h/%b/%b/%b/%h",
                 c, out_strobe, out_msg, owner, kb_active, ap_drop, noteid,
                 m_strobe, m_out_msg, m_owner, m_kb_active, m_ap_drop, m_noteid);
      end
    end
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    test_reset();
    test_ap_basic();
    test_priority();
    test_mute_drop();
    test_holdoff();
    test_overwrite();
    test_reset_mid_emit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
